// File: rtl/uart_rx_ctrl_if.sv
// Serial-line inputs, frame options and deserializer-side outputs of the UART RX controller.
// The controller uses the slave modport; the line/config side uses master.
interface uart_rx_ctrl_if;
    logic       RX_IN;
    logic [7:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic [5:0] edge_count;
    logic       deser_en;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  sampled_bit, edge_count, deser_en, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output sampled_bit, edge_count, deser_en, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: start detection, oversampling edge/bit counting, mid-bit 3-sample
// majority vote, parity/stop checking and one-cycle completion pulses per frame.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic           CLK,
    input logic           RST,
    uart_rx_ctrl_if.slave bus
);
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned EDGE_W = 6;
    localparam int unsigned PRE_W  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [EDGE_W-1:0]  edge_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sample0;
    logic               sample1;
    logic               sampled_q;
    logic               par_run;
    logic               par_en_q;
    logic               par_typ_q;
    logic               par_fail_q;
    logic               deser_en_q;
    logic               data_valid_q;
    logic               par_err_q;
    logic               stp_err_q;
    logic               deser_en_d;
    logic               data_valid_d;
    logic               par_err_d;
    logic               stp_err_d;
    logic [PRE_W-1:0]   edge_ext;
    logic [PRE_W-1:0]   half;
    logic               bit_end;
    logic               last_bit;
    logic               start_seen;
    logic               vote;

    assign edge_ext   = PRE_W'(edge_cnt);
    assign half       = bus.Prescale >> 1;
    assign bit_end    = (state != IDLE) && (edge_ext == bus.Prescale - PRE_W'(1));
    assign last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign start_seen = (state == IDLE) && !bus.RX_IN;
    assign vote       = (sample0 & sample1) | (sample0 & bus.RX_IN) | (sample1 & bus.RX_IN);

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: every bit decision is taken on the last edge of the bit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_seen) state_next = START;
            START:   if (bit_end) state_next = sampled_q ? IDLE : DATA;
            DATA:    if (bit_end && last_bit) state_next = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        deser_en_d   = 1'b0;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        deser_en_d   = (state_next == DATA);
        if (state == STOP && bit_end) begin
            par_err_d    = par_fail_q;
            stp_err_d    = ~sampled_q;
            data_valid_d = ~par_fail_q & sampled_q;
        end
    end

    // Counters, mid-bit voting and running parity
    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            sample0    <= 1'b0;
            sample1    <= 1'b0;
            sampled_q  <= 1'b1;
            par_run    <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
        end else if (state == IDLE) begin
            // The detection cycle is edge 0, so the first START cycle is edge 1
            edge_cnt   <= start_seen ? EDGE_W'(1) : '0;
            bit_cnt    <= '0;
            par_run    <= 1'b0;
            par_fail_q <= 1'b0;
            if (start_seen) begin
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
            end
        end else begin
            edge_cnt <= bit_end ? '0 : edge_cnt + EDGE_W'(1);
            if (edge_ext == half - PRE_W'(1)) sample0 <= bus.RX_IN;
            if (edge_ext == half) sample1 <= bus.RX_IN;
            if (edge_ext == half + PRE_W'(1)) sampled_q <= vote;
            if (bit_end && state == DATA) begin
                par_run <= par_run ^ sampled_q;
                if (!last_bit) bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (bit_end && state == PARITY) begin
                par_fail_q <= par_en_q && (sampled_q != (par_run ^ par_typ_q));
            end
        end
    end

    // Registered outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            deser_en_q   <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            deser_en_q   <= deser_en_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.sampled_bit = sampled_q;
    assign bus.edge_count  = edge_cnt;
    assign bus.deser_en    = deser_en_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.par_err     = par_err_q;
    assign bus.stp_err     = stp_err_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frames are expanded into per-cycle line waveforms and the
// recorded outputs are compared with timing/values computed from frame arithmetic.
module tb_uart_rx_ctrl;
    localparam int unsigned W = 8;

    typedef logic lq_t[$];

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    bit              wave[$];
    lq_t             dv_h, pe_h, se_h, de_h, sb_h;
    int              ec_h[$];
    logic [W-1:0]    cap_h[$];
    logic [W-1:0]    shreg;

    always #5 CLK = ~CLK;

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic int first_high(input lq_t q);
        foreach (q[i]) if (q[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int num_high(input lq_t q);
        int n = 0;
        foreach (q[i]) if (q[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic add_level(input int n, input bit b);
        for (int i = 0; i < n; i++) wave.push_back(b);
    endtask

    // Frame as a list of bit values, each stretched over p cycles; optional one-cycle spike
    task automatic add_frame(input int p, input bit pe, input bit pt, input logic [W-1:0] d,
                             input bit bad_par, input bit stop, input int spike_bit);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt ^ bad_par);
        bits.push_back(stop);
        foreach (bits[k])
            for (int e = 0; e < p; e++)
                wave.push_back((k == spike_bit + 1 && e == p / 2) ? ~bits[k] : bits[k]);
    endtask

    // Drive the queued waveform one value per cycle and record every output per cycle
    task automatic run_wave(input int p, input int rst_at);
        dv_h.delete(); pe_h.delete(); se_h.delete(); de_h.delete(); sb_h.delete();
        ec_h.delete(); cap_h.delete();
        shreg = '0;
        bus.Prescale = 8'(p);
        for (int c = 0; c < wave.size(); c++) begin
            @(posedge CLK); #1;
            bus.RX_IN = wave[c];
            RST = (c == rst_at) ? 1'b0 : 1'b1;
            dv_h.push_back(bus.data_valid);
            pe_h.push_back(bus.par_err);
            se_h.push_back(bus.stp_err);
            de_h.push_back(bus.deser_en);
            sb_h.push_back(bus.sampled_bit);
            ec_h.push_back(int'(bus.edge_count));
            if (bus.deser_en === 1'b1 && int'(bus.edge_count) == p - 1)
                shreg = {bus.sampled_bit, shreg[W-1:1]};
            cap_h.push_back(shreg);
        end
        wave.delete();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        bus.RX_IN = 1'b1; bus.Prescale = 8'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (bus.sampled_bit !== 1'b1) begin
            errors++; $display("FAIL reset_sampled_bit: got %b expected 1", bus.sampled_bit);
        end
        checks++;
        if ({bus.edge_count, bus.deser_en, bus.data_valid, bus.par_err, bus.stp_err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ec=%0d de=%b dv=%b pe=%b se=%b expected all 0",
                     bus.edge_count, bus.deser_en, bus.data_valid, bus.par_err, bus.stp_err);
        end
        RST = 1'b1;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_good_frame();
        bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        add_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1);
        add_level(8, 1'b1);
        run_wave(8, -1);
        checks++;
        if (first_high(dv_h) != 80 || num_high(dv_h) != 1) begin
            errors++; $display("FAIL good_dv_time: got first=%0d n=%0d expected 80 n=1",
                               first_high(dv_h), num_high(dv_h));
        end
        checks++;
        if (num_high(pe_h) + num_high(se_h) != 0) begin
            errors++; $display("FAIL good_no_err: got %0d error pulses expected 0",
                               num_high(pe_h) + num_high(se_h));
        end
        checks++;
        if (first_high(de_h) != 8 || num_high(de_h) != 64) begin
            errors++; $display("FAIL good_deser_en: got first=%0d n=%0d expected 8 n=64",
                               first_high(de_h), num_high(de_h));
        end
        checks++;
        if (cap_h[80] !== 8'hA5) begin
            errors++; $display("FAIL good_data: got %h expected a5", cap_h[80]);
        end
    endtask

    task automatic test_parity_err();
        bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
        add_frame(16, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, -1);
        add_level(8, 1'b1);
        run_wave(16, -1);
        checks++;
        if (first_high(pe_h) != 176 || num_high(pe_h) != 1) begin
            errors++; $display("FAIL par_err_time: got first=%0d n=%0d expected 176 n=1",
                               first_high(pe_h), num_high(pe_h));
        end
        checks++;
        if (num_high(dv_h) != 0 || num_high(se_h) != 0) begin
            errors++; $display("FAIL par_err_others: got dv=%0d se=%0d expected 0 0",
                               num_high(dv_h), num_high(se_h));
        end
        bus.PAR_EN = 1'b0;
    endtask

    task automatic test_stop_err();
        add_frame(8, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, -1);
        add_level(8, 1'b1);
        run_wave(8, -1);
        checks++;
        if (first_high(se_h) != 80 || num_high(se_h) != 1) begin
            errors++; $display("FAIL stp_err_time: got first=%0d n=%0d expected 80 n=1",
                               first_high(se_h), num_high(se_h));
        end
        checks++;
        if (num_high(dv_h) != 0 || num_high(pe_h) != 0) begin
            errors++; $display("FAIL stp_err_others: got dv=%0d pe=%0d expected 0 0",
                               num_high(dv_h), num_high(pe_h));
        end
        checks++;
        if (cap_h[80] !== 8'h3C) begin
            errors++; $display("FAIL stp_err_data: got %h expected 3c", cap_h[80]);
        end
    endtask

    task automatic test_glitch_and_vote();
        add_level(2, 1'b0);
        add_level(30, 1'b1);
        run_wave(16, -1);
        checks++;
        if (ec_h[15] != 15 || ec_h[16] != 0 || ec_h[17] != 0) begin
            errors++; $display("FAIL glitch_idle: got ec15=%0d ec16=%0d ec17=%0d expected 15 0 0",
                               ec_h[15], ec_h[16], ec_h[17]);
        end
        checks++;
        if (num_high(de_h) + num_high(dv_h) + num_high(pe_h) + num_high(se_h) != 0) begin
            errors++; $display("FAIL glitch_quiet: got %0d high cycles expected 0",
                               num_high(de_h) + num_high(dv_h) + num_high(pe_h) + num_high(se_h));
        end
        add_frame(16, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 3);
        add_level(8, 1'b1);
        run_wave(16, -1);
        checks++;
        if (sb_h[79] !== 1'b0) begin
            errors++; $display("FAIL vote_bit3: got %b expected 0", sb_h[79]);
        end
        checks++;
        if (dv_h[160] !== 1'b1 || cap_h[160] !== 8'hA5) begin
            errors++; $display("FAIL vote_frame: got dv=%b data=%h expected 1 a5",
                               dv_h[160], cap_h[160]);
        end
    endtask

    task automatic test_reset_mid();
        add_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1);
        add_level(8, 1'b1);
        for (int c = 41; c < wave.size(); c++) wave[c] = 1'b1;
        run_wave(8, 40);
        checks++;
        if (ec_h[41] != 0 || sb_h[41] !== 1'b1 || de_h[41] !== 1'b0) begin
            errors++; $display("FAIL reset_mid_state: got ec=%0d sb=%b de=%b expected 0 1 0",
                               ec_h[41], sb_h[41], de_h[41]);
        end
        checks++;
        if (num_high(dv_h) + num_high(pe_h) + num_high(se_h) != 0) begin
            errors++; $display("FAIL reset_mid_pulse: got %0d pulses expected 0",
                               num_high(dv_h) + num_high(pe_h) + num_high(se_h));
        end
    endtask

    task automatic test_back_to_back();
        add_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1);
        add_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1);
        add_level(8, 1'b1);
        run_wave(8, -1);
        checks++;
        if (dv_h[80] !== 1'b1 || dv_h[160] !== 1'b1 || num_high(dv_h) != 2) begin
            errors++; $display("FAIL b2b_dv: got dv80=%b dv160=%b n=%0d expected 1 1 2",
                               dv_h[80], dv_h[160], num_high(dv_h));
        end
        checks++;
        if (cap_h[80] !== 8'hA5 || cap_h[160] !== 8'h5A) begin
            errors++; $display("FAIL b2b_data: got %h %h expected a5 5a", cap_h[80], cap_h[160]);
        end
    endtask

    task automatic test_random();
        int           p, t, gap, anyn;
        int           pcs[$];
        bit           edv[$], epe[$], ese[$];
        logic [W-1:0] ds[$];
        logic [W-1:0] d;
        bit           bp, sb;
        for (int it = 0; it < 5; it++) begin
            pcs.delete(); edv.delete(); epe.delete(); ese.delete(); ds.delete();
            p = 8 << $urandom_range(2, 0);
            bus.PAR_EN  = 1'($urandom_range(1, 0));
            bus.PAR_TYP = 1'($urandom_range(1, 0));
            t = 0;
            for (int f = 0; f < 3; f++) begin
                d   = W'($urandom);
                bp  = ($urandom_range(3, 0) == 0);
                sb  = ($urandom_range(3, 0) != 0);
                gap = $urandom_range(2, 0);
                add_frame(p, bus.PAR_EN, bus.PAR_TYP, d, bp, sb, -1);
                t += p * (W + 2 + int'(bus.PAR_EN));
                pcs.push_back(t);
                epe.push_back(bus.PAR_EN && bp);
                ese.push_back(!sb);
                edv.push_back(!(bus.PAR_EN && bp) && sb);
                ds.push_back(d);
                add_level(gap, 1'b1);
                t += gap;
            end
            add_level(4, 1'b1);
            run_wave(p, -1);
            foreach (pcs[f]) begin
                checks++;
                if (dv_h[pcs[f]] !== edv[f] || pe_h[pcs[f]] !== epe[f] || se_h[pcs[f]] !== ese[f]) begin
                    errors++;
                    $display("FAIL rand_pulses it%0d f%0d P=%0d: got dv=%b pe=%b se=%b expected %b %b %b",
                             it, f, p, dv_h[pcs[f]], pe_h[pcs[f]], se_h[pcs[f]], edv[f], epe[f], ese[f]);
                end
                checks++;
                if (cap_h[pcs[f]] !== ds[f]) begin
                    errors++; $display("FAIL rand_data it%0d f%0d: got %h expected %h",
                                       it, f, cap_h[pcs[f]], ds[f]);
                end
            end
            anyn = 0;
            foreach (dv_h[c]) if ((dv_h[c] | pe_h[c] | se_h[c]) === 1'b1) anyn++;
            checks++;
            if (anyn != 3 || num_high(de_h) != 3 * W * p) begin
                errors++; $display("FAIL rand_counts it%0d: got pulses=%0d de=%0d expected 3 %0d",
                                   it, anyn, num_high(de_h), 3 * W * p);
            end
        end
        bus.PAR_EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_stop_err();
        test_glitch_and_vote();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART RX path. It sits directly upstream of the deserializer and drives that stage's `sampled_bit`, `Enable` and `edge_count` inputs. Internally it detects the start bit, counts oversampling edges and bits, and takes a 3-sample majority vote at mid-bit. It also checks the parity and stop bits and reports frame completion or error per received frame.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, LSB first.
- `CLK`  in  1  oversampling clock; all logic on rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `RX_IN`  in  1  serial line, idle high.
- `Prescale`  in  8  oversampling ratio; only 8, 16, 32 supported, no checking; must be static while a frame is in progress.
- `PAR_EN`  in  1  1 = frame carries a parity bit after the data bits.
- `PAR_TYP`  in  1  0 = even, 1 = odd parity.
- `sampled_bit`  out  1  majority-voted bit value, to deserializer.
- `edge_count`  out  6  current edge index within the bit, 0..Prescale-1, to deserializer.
- `deser_en`  out  1  high throughout DATA state, to deserializer `Enable`.
- `data_valid`  out  1  one-cycle pulse: frame received without error.
- `par_err`  out  1  one-cycle pulse: parity mismatch.
- `stp_err`  out  1  one-cycle pulse: stop bit sampled 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - edge_count = 0; bit counter = 0; running parity cleared.
  - When RX_IN = 0, go to START. That detection cycle counts as edge 0.
- Edge counter:
  - Outside IDLE, increments every cycle.
  - At Prescale-1 it wraps to 0, and the bit counter increments (DATA state only).
- Majority vote:
  - RX_IN is captured at edge_count = Prescale/2-1 and Prescale/2.
  - On the edge where edge_count = Prescale/2+1, sampled_bit ← majority(sample0, sample1, RX_IN).
  - sampled_bit is held otherwise.
- All bit decisions are made at edge_count = Prescale-1 using sampled_bit.
- START: sampled_bit = 0 → DATA. sampled_bit = 1 → IDLE (glitch); no flag, no pulse.
- DATA:
  - deser_en = 1.
  - Running parity ^= sampled_bit at each bit end.
  - After bit DATA_WIDTH-1 ends → PARITY if PAR_EN, else STOP.
- PARITY: par_fail = (sampled_bit ≠ running_parity ^ PAR_TYP) → STOP.
- STOP: stop_fail = ~sampled_bit → IDLE.
- Completion pulses, in the cycle after STOP ends:
  - par_err = par_fail.
  - stp_err = stop_fail.
  - data_valid = ~par_fail & ~stop_fail.
  - All three last exactly one cycle.
- par_fail is forced to 0 when PAR_EN = 0.
- PAR_EN and PAR_TYP are sampled at the IDLE→START transition and held for the frame.
- Reset values: sampled_bit = 1; all other outputs 0; state IDLE; all counters 0.

## Timing
- Relative to detection cycle t0 (IDLE, RX_IN = 0 seen):
  - Start bit occupies cycles t0..t0+P-1.
  - Data bit i occupies cycles t0+P(i+1) .. t0+P(i+2)-1.
- Without parity, the STOP bit ends at t0+P(DATA_WIDTH+2)-1 and pulses appear at t0+P(DATA_WIDTH+2). For P = 8, width 8, this is t0+80.
- With parity, everything after the data bits shifts by P. For P = 8, width 8, pulses appear at t0+88.
- sampled_bit is valid from edge Prescale/2+2 onward, so it is stable when the deserializer shifts at edge_count = Prescale-1.
- deser_en is high for exactly DATA_WIDTH·P cycles per good frame.
- Back-to-back frames: the pulse cycle is an IDLE cycle. If RX_IN = 0 in that cycle, the next start is detected in it with no dead cycle.
- Synchronous reset mid-frame: at the next edge the state is IDLE, counters are 0, and outputs are at reset values. No pulse is emitted for the aborted frame.
- Simultaneous events: if reset and completion coincide in the same cycle, reset wins.

## Test plan
- Good frame, no parity:
  - Stimulus: P = 8, PAR_EN = 0, RX_IN = start, 0xA5 LSB first (1,0,1,0,0,1,0,1), stop.
  - Response: data_valid high only at t0+80; deser_en high for t0+8..t0+71; deserializer holds P_DATA = 0xA5.
- Parity error:
  - Stimulus: P = 16, PAR_EN = 1, PAR_TYP = 0, data 0xA5 (four ones, so the correct bit is 0), parity bit sent as 1.
  - Response: par_err pulse at t0+176; data_valid stays 0.
- Stop error:
  - Stimulus: P = 8, PAR_EN = 0, data 0x3C, stop bit driven 0.
  - Response: stp_err pulse at t0+80; data_valid 0.
- Start glitch and majority vote:
  - Stimulus 1: P = 16, RX_IN low for 2 cycles only. Response: return to IDLE at t0+16; no pulses; deser_en never high.
  - Stimulus 2: separately, a 1-cycle inverted spike at edge Prescale/2 inside data bit 3. Response: the bit is still sampled correctly.
- Reset mid-frame and back-to-back:
  - Stimulus 1: RST low at t0+40 of a P = 8 frame. Response: next cycle has all outputs 0, sampled_bit 1, no pulse.
  - Stimulus 2: two frames sent with the second start beginning at t0+80. Response: both frames give data_valid, at t0+80 and t0+160.
